// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 INCR-burst slave over synchronous word RAM, independent read/write engines.
// Define AXI_RAM_RANGE_CHECK_EN to answer DECERR for beats outside the RAM window.
module axi_ram_slave #(
  parameter int C_S_AXI_ID_WIDTH = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_ADDR_BITS = 10,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0000_0000
) (
  input  logic CLK,
  input  logic RST,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0] S_AXI_AWLEN,
  input  logic S_AXI_AWVALID,
  output logic S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic S_AXI_WLAST,
  input  logic S_AXI_WVALID,
  output logic S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0] S_AXI_BRESP,
  output logic S_AXI_BVALID,
  input  logic S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0] S_AXI_ARLEN,
  input  logic S_AXI_ARVALID,
  output logic S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0] S_AXI_RRESP,
  output logic S_AXI_RLAST,
  output logic S_AXI_RVALID,
  input  logic S_AXI_RREADY
);
`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam int OW = C_S_AXI_ADDR_WIDTH - 2;
`else
  localparam int OW = C_MEM_ADDR_BITS;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [1<<C_MEM_ADDR_BITS];
  logic [OW-1:0] w_off, r_off;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_slv, w_dec, w_ok, r_ok;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, fetch;
  // Word offsets from the window base; wide enough in range-check builds to spot beats past the end
`ifdef AXI_RAM_RANGE_CHECK_EN
  assign w_ok = (w_off >> C_MEM_ADDR_BITS) == '0;
  assign r_ok = (r_off >> C_MEM_ADDR_BITS) == '0;
`else
  assign w_ok = 1'b1;
  assign r_ok = 1'b1;
`endif
  assign S_AXI_AWREADY = w_state == W_IDLE && !RST;
  assign S_AXI_WREADY = w_state == W_DATA;
  assign S_AXI_BVALID = w_state == W_RESP;
  assign S_AXI_BRESP = {w_dec | w_slv, w_dec};
  assign S_AXI_ARREADY = r_state == R_IDLE && !RST;
  assign S_AXI_RVALID = r_state == R_DATA;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs = S_AXI_RVALID && S_AXI_RREADY;
  // Load the output register for the first beat, then again on every non-final accepted beat
  assign fetch = r_state == R_FETCH || (r_hs && !S_AXI_RLAST);
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = aw_hs ? W_DATA : W_IDLE;
      W_DATA: w_next = (w_hs && w_cnt == w_len) ? W_RESP : W_DATA;
      W_RESP: w_next = b_hs ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: r_next = ar_hs ? R_FETCH : R_IDLE;
      R_FETCH: r_next = R_DATA;
      R_DATA: r_next = (r_hs && S_AXI_RLAST) ? R_IDLE : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state <= W_IDLE;
      S_AXI_BID <= '0;
      w_off <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_slv <= 1'b0;
      w_dec <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        S_AXI_BID <= S_AXI_AWID;
        w_off <= OW'((S_AXI_AWADDR - C_BASE_ADDR) >> 2);
        w_len <= S_AXI_AWLEN;
        w_cnt <= '0;
        w_slv <= 1'b0;
        w_dec <= 1'b0;
      end
      if (w_hs) begin
        w_off <= w_off + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        w_slv <= w_slv | (S_AXI_WLAST != (w_cnt == w_len));
        w_dec <= w_dec | !w_ok;
      end
    end
  end
  always_ff @(posedge CLK)
    if (w_hs && w_ok)
      for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
        if (S_AXI_WSTRB[b]) mem[w_off[C_MEM_ADDR_BITS-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= R_IDLE;
      S_AXI_RID <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
      S_AXI_RLAST <= 1'b0;
      r_off <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        S_AXI_RID <= S_AXI_ARID;
        r_off <= OW'((S_AXI_ARADDR - C_BASE_ADDR) >> 2);
        r_len <= S_AXI_ARLEN;
        r_cnt <= '0;
      end
      if (r_hs && S_AXI_RLAST) S_AXI_RLAST <= 1'b0;
      if (fetch) begin
        S_AXI_RDATA <= r_ok ? mem[r_off[C_MEM_ADDR_BITS-1:0]] : '0;
        S_AXI_RRESP <= r_ok ? 2'b00 : 2'b11;
        S_AXI_RLAST <= r_cnt == r_len;
        r_off <= r_off + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed bench for axi_ram_slave with window base 0x1000_0000.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic RST;
  logic [0:0] S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0] S_AXI_AWLEN, S_AXI_ARLEN;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  int checks = 0;
  int errors = 0;

  axi_ram_slave #(.C_BASE_ADDR(32'h1000_0000)) dut (
    .CLK(clk), .RST(RST),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int ch);
    return ch == 0 ? S_AXI_AWREADY : ch == 1 ? S_AXI_WREADY : ch == 2 ? S_AXI_ARREADY : S_AXI_BVALID;
  endfunction

  // Waits for the handshake on one channel; returns #1 after the accepting edge
  task automatic hs(input int ch, input string tag);
    int t = 0;
    logic r;
    do begin
      @(negedge clk);
      r = rdy(ch);
      step();
      t++;
    end while (!r && t < 50);
    chk({tag, "_handshake"}, 32'(r), 32'd1);
  endtask

  task automatic wr(input logic id, input logic [31:0] addr, input int len, input logic [31:0] d0,
                    input logic [3:0] strb, input int last_at, input logic [1:0] resp);
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWVALID = 1'b1;
    hs(0, "aw");
    S_AXI_AWVALID = 1'b0;
    chk("wready_after_aw", 32'(S_AXI_WREADY), 32'd1);
    for (int i = 0; i <= len; i++) begin
      S_AXI_WDATA = d0 + i; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
      hs(1, "w");
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("bvalid_after_w", 32'(S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(S_AXI_BRESP), 32'(resp));
    chk("bid", 32'(S_AXI_BID), 32'(id));
    S_AXI_BREADY = 1'b1;
    hs(3, "b");
    S_AXI_BREADY = 1'b0;
    chk("awready_after_b", 32'(S_AXI_AWREADY), 32'd1);
  endtask

  task automatic rd(input logic id, input logic [31:0] addr, input int len, input logic [31:0] e0,
                    input logic [31:0] inc, input bit stall, input logic [1:0] resp);
    int beat = 0;
    int cyc = 0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARVALID = 1'b1;
    hs(2, "ar");
    S_AXI_ARVALID = 1'b0;
    while (beat <= len && cyc < 200) begin
      S_AXI_RREADY = stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      if (S_AXI_RVALID) begin
        if (!stall) chk("r_latency", 32'(cyc), 32'(beat + 1));
        chk("rdata", S_AXI_RDATA, e0 + inc * beat);
        chk("rlast", 32'(S_AXI_RLAST), 32'(beat == len));
        chk("rid", 32'(S_AXI_RID), 32'(id));
        chk("rresp", 32'(S_AXI_RRESP), 32'(resp));
        if (S_AXI_RREADY) beat++;
      end
      step();
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    chk("r_beats", 32'(beat), 32'(len + 1));
    chk("arready_after_r", 32'(S_AXI_ARREADY), 32'd1);
    chk("rvalid_after_r", 32'(S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID} = '0;
    {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY} = '0;
    {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID, S_AXI_RREADY} = '0;
    repeat (3) step();
    chk("reset_ctrl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID,
                           S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RID}), 32'd0);
    chk("reset_rdata", S_AXI_RDATA, 32'd0);
    RST = 1'b0;
    #1;
    chk("awready_after_rst", 32'(S_AXI_AWREADY), 32'd1);
    chk("arready_after_rst", 32'(S_AXI_ARREADY), 32'd1);
    step();
    wr(1'b1, 32'h1000_0010, 0, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    rd(1'b1, 32'h1000_0010, 0, 32'hDEAD_BEEF, 32'd0, 1'b0, 2'b00);
    wr(1'b0, 32'h1000_0020, 0, 32'hAABB_CCDD, 4'hF, 0, 2'b00);
    wr(1'b1, 32'h1000_0020, 0, 32'h1122_3344, 4'b0101, 0, 2'b00);
    rd(1'b0, 32'h1000_0020, 0, 32'hAA22_CC44, 32'd0, 1'b0, 2'b00);
    wr(1'b0, 32'h1000_0000, 15, 32'd0, 4'hF, 15, 2'b00);
    rd(1'b1, 32'h1000_0000, 15, 32'd0, 32'd1, 1'b0, 2'b00);
    rd(1'b0, 32'h1000_0010, 3, 32'd4, 32'd1, 1'b1, 2'b00);
    wr(1'b0, 32'h1000_0100, 3, 32'hA0, 4'hF, 1, 2'b10);
    rd(1'b1, 32'h1000_0100, 3, 32'hA0, 32'd1, 1'b0, 2'b00);
    wr(1'b1, 32'h1000_0200, 1, 32'hB0, 4'hF, 255, 2'b10);
`ifdef AXI_RAM_RANGE_CHECK_EN
    rd(1'b0, 32'h1000_1000, 1, 32'd0, 32'd0, 1'b0, 2'b11);
`else
    rd(1'b0, 32'h1000_1000, 1, 32'd0, 32'd1, 1'b0, 2'b00);
`endif
    S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h1000_0000; S_AXI_ARLEN = 8'd7; S_AXI_ARVALID = 1'b1;
    hs(2, "ar_rst");
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    repeat (3) step();
    chk("rst_burst_beat2", S_AXI_RDATA, 32'd2);
    RST = 1'b1;
    step();
    chk("rst_abort", 32'({S_AXI_RVALID, S_AXI_RLAST, S_AXI_ARREADY, S_AXI_BVALID}), 32'd0);
    RST = 1'b0;
    S_AXI_RREADY = 1'b0;
    #1;
    chk("arready_after_abort", 32'(S_AXI_ARREADY), 32'd1);
    step();
    chk("no_rvalid_after_abort", 32'(S_AXI_RVALID), 32'd0);
    rd(1'b1, 32'h1000_0008, 0, 32'd2, 32'd0, 1'b0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 slave (responder) backed by on-chip word RAM; the memory-side counterpart of the CPU data-cache AXI master. Accepts single-beat and INCR burst reads/writes with byte strobes, one outstanding transaction per direction, and independent read and write engines. Used as data/device memory behind the interconnect and as the bench target for the cache master.

## Interface
- C_S_AXI_ID_WIDTH, 1, AXI ID width; IDs are echoed on B/R.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_MEM_ADDR_BITS, 10, log2 of RAM depth in 32-bit words (default 4 KiB).
- C_BASE_ADDR, 32'h0000_0000, byte base address of the RAM window.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- S_AXI_AWID / AWADDR / AWLEN / AWVALID  in  ID / ADDR / 8 / 1  write address; AWREADY out 1.
- S_AXI_WDATA / WSTRB / WLAST / WVALID  in  32 / 4 / 1 / 1  write data; WREADY out 1.
- S_AXI_BID / BRESP / BVALID  out  ID / 2 / 1  write response; BREADY in 1.
- S_AXI_ARID / ARADDR / ARLEN / ARVALID  in  ID / ADDR / 8 / 1  read address; ARREADY out 1.
- S_AXI_RID / RDATA / RRESP / RLAST / RVALID  out  ID / 32 / 2 / 1 / 1  read data; RREADY in 1.
- Size is fixed at 4 bytes and burst type at INCR; SIZE/BURST/LOCK/CACHE/PROT/QOS/USER are not ports.

## Operation
- Word index = (addr - C_BASE_ADDR)[C_MEM_ADDR_BITS+1:2]; addr[1:0] ignored. Burst address increments by 4 per beat, wrapping modulo RAM depth.
- Write FSM: W_IDLE (AWREADY=1) -> on AW handshake latch ID/addr/len, beat count=0 -> W_DATA (WREADY=1); each W handshake writes bytes whose WSTRB bit is 1, increments addr and count -> after beat AWLEN+1 -> W_RESP (BVALID=1, BRESP=OKAY) -> on BREADY -> W_IDLE.
- The burst ends on the beat counter; WLAST is not used for termination. A WLAST mismatch (early or missing) sets BRESP=SLVERR (2'b10); all AWLEN+1 beats are still accepted.
- Read FSM: R_IDLE (ARREADY=1) -> on AR handshake latch ID/addr/len -> R_FETCH (synchronous RAM read) -> R_DATA (RVALID=1). A prefetch register keeps RDATA stable while RVALID&&!RREADY and sustains one beat per cycle while RREADY=1. RLAST=1 only on beat ARLEN+1. Final R handshake -> R_IDLE.
- Read and write engines run concurrently. A same-word read and write in the same cycle returns the old data. A read whose AR handshake follows the B handshake of a write returns the new data.
- RAM contents are not reset and not initialized.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, RID=0. AWREADY/ARREADY rise on the first cycle after RST falls.
- Write: AW handshake at T; WREADY=1 from T+1; BVALID rises the cycle after the last W handshake; AWREADY rises the cycle after the B handshake.
- Read: AR handshake at T; first RVALID at T+2; with RREADY held high, beat n appears at T+2+n; ARREADY rises the cycle after the final R handshake.
- VALID, once asserted, holds with stable payload until its handshake.
- RST mid-burst aborts both FSMs to IDLE with no B/R issued. RAM writes already performed remain.

## Configuration
- AXI_RAM_RANGE_CHECK_EN defined: any beat address outside [C_BASE_ADDR, C_BASE_ADDR + 4·2^C_MEM_ADDR_BITS) gives DECERR (2'b11). Writes are suppressed and BRESP=DECERR if any beat was out of range. Out-of-range read beats return RDATA=0 with RRESP=DECERR.
- Not defined: no range check; addresses alias modulo RAM size; responses are OKAY except the WLAST-mismatch SLVERR.

## Test plan
- Single write 0x1000_0010 (with base 0x1000_0000) = 0xDEADBEEF, WSTRB 4'hF, then single read -> BRESP=0; RDATA=0xDEADBEEF at T+2; RLAST=1.
- Write WSTRB 4'b0101 data 0x11223344 over 0xAABBCCDD -> readback 0xAA22CC44.
- 16-beat INCR write of i at word i, then AWLEN/ARLEN=15 read with RREADY=1 -> 16 consecutive beats 0..15, RLAST on beat 15 only, RID=ARID.
- 4-beat read with RREADY toggling 1,0,0,1,... -> RDATA stable while stalled, no beat lost or duplicated.
- Write with WLAST on beat 2 of AWLEN=3 -> 4 beats accepted, BRESP=SLVERR. Read at 0x1000_1000 -> OKAY with aliasing (macro off), or DECERR with RDATA=0 (macro on).
- Assert RST at beat 2 of an 8-beat read -> RVALID=0 next cycle, ARREADY=1 the cycle after RST falls, no RLAST.
